hazard_detect_unit: RTL

// Producer side of the EX-stage forwarding mux. Tracks destination registers of the
// in-flight EXE/MEM/WB instructions in a shadow pipeline, compares them to the ID-stage

---
 rtl/mips_hazard_pkg.sv | 20 ++
 rtl/hazard_match.sv | 23 ++
 rtl/hazard_detect_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared shadow-pipeline types and the per-stage write-match helper
package mips_hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } stage_entry_t;

    typedef enum logic [1:0] {EXE, MEM, WB} stage_t;

    function automatic logic entry_writes(input stage_entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid & e.wr_en & (e.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: priority comparator of one source index against the EXE/MEM/WB shadow entries
module hazard_match
    import mips_hazard_pkg::*;
(
    input  logic                    i_en,
    input  logic [REG_ADDR_W-1:0]   i_src,
    input  stage_entry_t [2:0]      i_stages,
    output logic                    o_exe,
    output logic                    o_mem,
    output logic                    o_wb
);
    logic w_m_exe, w_m_mem, w_m_wb;

    assign w_m_exe = entry_writes(i_stages[EXE], i_src);
    assign w_m_mem = entry_writes(i_stages[MEM], i_src);
    assign w_m_wb  = entry_writes(i_stages[WB], i_src);

    // youngest writer wins so the mux forwards the most recent value
    assign o_exe = i_en & w_m_exe;
    assign o_mem = i_en & w_m_mem & ~w_m_exe;
    assign o_wb  = i_en & w_m_wb & ~w_m_mem & ~w_m_exe;

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: shadow EXE/MEM/WB destination tracking, forwarding flags and load-use stall
module hazard_detect_unit
    import mips_hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]   id_rt,
    input  logic                    id_uses_rs,
    input  logic                    id_uses_rt,
    input  logic                    id_uses_store_val,
    input  logic                    id_wr_en,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    id_is_load,
    input  logic                    flush,
    input  logic                    mem_stall,
    output logic                    has_reg1_hazard,
    output logic                    has_reg2_hazard,
    output logic                    has_saved_val_hazard,
    output logic                    is_reg1_EXE_hazard,
    output logic                    is_reg1_MEM_hazard,
    output logic                    is_reg1_WB_hazard,
    output logic                    is_reg2_EXE_hazard,
    output logic                    is_reg2_MEM_hazard,
    output logic                    is_reg2_WB_hazard,
    output logic                    stall_id,
    output logic [STALL_CNT_W-1:0]  stall_count
);
    stage_entry_t [2:0]      r_stages;
    logic [STALL_CNT_W-1:0]  r_stall_count;
    stage_entry_t            w_id_entry;
    logic                    w_reg2_any;

    hazard_match u_match_rs (
        .i_en     (id_valid & id_uses_rs),
        .i_src    (id_rs),
        .i_stages (r_stages),
        .o_exe    (is_reg1_EXE_hazard),
        .o_mem    (is_reg1_MEM_hazard),
        .o_wb     (is_reg1_WB_hazard)
    );

    hazard_match u_match_rt (
        .i_en     (id_valid & (id_uses_rt | id_uses_store_val)),
        .i_src    (id_rt),
        .i_stages (r_stages),
        .o_exe    (is_reg2_EXE_hazard),
        .o_mem    (is_reg2_MEM_hazard),
        .o_wb     (is_reg2_WB_hazard)
    );

    assign has_reg1_hazard      = is_reg1_EXE_hazard | is_reg1_MEM_hazard | is_reg1_WB_hazard;
    assign w_reg2_any           = is_reg2_EXE_hazard | is_reg2_MEM_hazard | is_reg2_WB_hazard;
    assign has_reg2_hazard      = id_uses_rt & w_reg2_any;
    assign has_saved_val_hazard = id_uses_store_val & w_reg2_any;

    // a load in EXE has no result yet, so any consumer of it must wait one cycle
    assign stall_id = id_valid & ~flush & r_stages[EXE].is_load & (is_reg1_EXE_hazard | is_reg2_EXE_hazard);

    assign w_id_entry = '{valid: id_valid & ~stall_id & ~flush, wr_en: id_wr_en, rd: id_rd, is_load: id_is_load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stages      <= '0;
            r_stall_count <= '0;
        end else if (!mem_stall) begin
            r_stages[WB]  <= r_stages[MEM];
            r_stages[MEM] <= r_stages[EXE];
            r_stages[EXE] <= w_id_entry;
            if (stall_id && !(&r_stall_count))
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule
